// File: rtl/fp16_quad_feeder.sv
// Operand packer and result register around an external four-operand FP16 adder tree.
// Optional sticky exception flags are built when QUAD_FEEDER_STICKY_FLAGS_EN is defined.
module fp16_quad_feeder #(
   parameter int FLAGS_W = 5
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [15:0]        in_data,
   input  logic               flush,
   input  logic [2:0]         sub_op,
   input  logic [2:0]         rounding_mode,
   output logic [15:0]        add_a,
   output logic [15:0]        add_b,
   output logic [15:0]        add_c,
   output logic [15:0]        add_d,
   output logic [2:0]         add_sub_op,
   output logic [2:0]         add_rounding_mode,
   input  logic [15:0]        add_out,
   input  logic [FLAGS_W-1:0] add_flags,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        out_data,
   output logic [FLAGS_W-1:0] out_flags,
   input  logic               flags_clear,
   output logic [FLAGS_W-1:0] sticky_flags
);

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_EVAL = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [3:0][15:0]    opnd_q, opnd_d;
   logic [2:0]          sub_q, sub_d;
   logic [2:0]          rm_q, rm_d;
   logic [15:0]         res_q, res_d;
   logic [FLAGS_W-1:0]  flg_q, flg_d;
   logic                accept_s;
   logic [1:0]          cnt_next_s;

   // Next-state and datapath update for the fill / evaluate / hold sequence
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      opnd_d     = opnd_q;
      sub_d      = sub_q;
      rm_d       = rm_q;
      res_d      = res_q;
      flg_d      = flg_q;
      accept_s   = 1'b0;
      cnt_next_s = cnt_q;
      case (state_q)
         ST_FILL: begin
            accept_s = in_valid;
            if (accept_s) begin
               opnd_d[cnt_q] = in_data;
               cnt_next_s    = cnt_q + 2'd1;
               // the quad's controls are fixed by its first operand
               if (cnt_q == 2'd0) begin
                  sub_d = sub_op;
                  rm_d  = rounding_mode;
               end else begin
                  sub_d = sub_q;
                  rm_d  = rm_q;
               end
            end else begin
               cnt_next_s = cnt_q;
            end
            if (accept_s && (cnt_q == 2'd3)) begin
               state_d = ST_EVAL;
               cnt_d   = 2'd0;
            end else if (flush && (cnt_next_s != 2'd0)) begin
               for (int i = 0; i < 4; i++) begin
                  if (i >= int'(cnt_next_s)) begin
                     opnd_d[i] = 16'h0000;
                  end else begin
                     opnd_d[i] = opnd_d[i];
                  end
               end
               state_d = ST_EVAL;
               cnt_d   = 2'd0;
            end else begin
               state_d = ST_FILL;
               cnt_d   = cnt_next_s;
            end
         end
         ST_EVAL: begin
            res_d   = add_out;
            flg_d   = add_flags;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_FILL;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_FILL;
            cnt_d   = 2'd0;
         end
      endcase
   end

   // State, operand and result registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_FILL;
         cnt_q   <= 2'd0;
         opnd_q  <= '0;
         sub_q   <= 3'd0;
         rm_q    <= 3'd0;
         res_q   <= 16'h0000;
         flg_q   <= {FLAGS_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opnd_q  <= opnd_d;
         sub_q   <= sub_d;
         rm_q    <= rm_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
   end

   assign in_ready          = (state_q == ST_FILL);
   assign out_valid         = (state_q == ST_HOLD);
   assign add_a             = opnd_q[0];
   assign add_b             = opnd_q[1];
   assign add_c             = opnd_q[2];
   assign add_d             = opnd_q[3];
   assign add_sub_op        = sub_q;
   assign add_rounding_mode = rm_q;
   assign out_data          = res_q;
   assign out_flags         = flg_q;

`ifdef QUAD_FEEDER_STICKY_FLAGS_EN
   logic [FLAGS_W-1:0] sticky_q, sticky_d;

   // Accumulate delivered flags; a clear overrides a same-cycle handshake
   always_comb begin
      sticky_d = sticky_q;
      if (flags_clear) begin
         sticky_d = {FLAGS_W{1'b0}};
      end else if ((state_q == ST_HOLD) && out_ready) begin
         sticky_d = sticky_q | flg_q;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // Sticky flag register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sticky_q <= {FLAGS_W{1'b0}};
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_flags = sticky_q;
`else
   logic unused_flags_clear_s;
   assign unused_flags_clear_s = flags_clear;
   assign sticky_flags         = {FLAGS_W{1'b0}};
`endif

endmodule
